// File: rtl/if_prefetch_unit_pkg.sv
// Shared fetch-side types and constants for the instruction prefetch unit.
package if_prefetch_unit_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_INC  = 4;

   // Fetch FSM: IDLE (no request), FETCH (live request), DROP (stale request in flight)
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDrop  = 2'd2
   } fetch_state_e;

   // One buffered fetch result at the default 32-bit address width
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with flush; head entry reads as zero when empty.
module if_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pop on empty is ignored; a full FIFO accepts a push only alongside a pop
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   // Pointer and occupancy bookkeeping; flush wins over push and pop
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues imem requests and buffers results.
module if_prefetch_unit
   import if_prefetch_unit_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk_i,
   input  logic               rst_n,
   input  logic               redirect_i,
   input  logic [ADDR_W-1:0]  redirect_pc_i,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   input  logic               instr_ready_i
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned ENT_W = ADDR_W + INSTR_W;

   fetch_state_e      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pc_plus;
   logic [ADDR_W-1:0] redirect_pc_al;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic              push;
   logic              pop_eff;
   logic              room;
   logic [ENT_W-1:0]  head;

   assign redirect_pc_al = redirect_pc_i & ~ADDR_W'(3);
   assign pc_plus        = fetch_pc + ADDR_W'(PC_INC);

   // Only a live (non-stale) acked request fills the buffer; a redirect discards it
   assign push    = (state == StFetch) && imem_ack_i && !redirect_i;
   assign pop_eff = instr_ready_i && (count != '0);

   // Occupancy after this edge decides whether another request may be launched
   always_comb begin
      count_next = '0;
      if (!redirect_i) begin
         count_next = count + CNT_W'(push) - CNT_W'(pop_eff);
      end
   end

   assign room = (count_next < CNT_W'(DEPTH));

   // Fetch FSM with registered request/address outputs
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state       <= StIdle;
         fetch_pc    <= RESET_PC;
         imem_req_o  <= 1'b0;
         imem_addr_o <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (redirect_i) begin
                  fetch_pc    <= redirect_pc_al;
                  state       <= StFetch;
                  imem_req_o  <= 1'b1;
                  imem_addr_o <= redirect_pc_al;
               end else if (room) begin
                  state       <= StFetch;
                  imem_req_o  <= 1'b1;
                  imem_addr_o <= fetch_pc;
               end
            end
            StFetch: begin
               if (redirect_i) begin
                  fetch_pc <= redirect_pc_al;
                  if (imem_ack_i) begin
                     imem_addr_o <= redirect_pc_al;
                  end else begin
                     // Address must stay on the old request until memory acks it
                     state <= StDrop;
                  end
               end else if (imem_ack_i) begin
                  fetch_pc <= pc_plus;
                  if (room) begin
                     imem_addr_o <= pc_plus;
                  end else begin
                     state      <= StIdle;
                     imem_req_o <= 1'b0;
                  end
               end
            end
            StDrop: begin
               if (redirect_i) fetch_pc <= redirect_pc_al;
               if (imem_ack_i) begin
                  state       <= StFetch;
                  imem_addr_o <= redirect_i ? redirect_pc_al : fetch_pc;
               end
            end
            default: begin
               state      <= StIdle;
               imem_req_o <= 1'b0;
            end
         endcase
      end
   end

   if_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_n),
      .push  (push),
      .pop   (instr_ready_i),
      .flush (redirect_i),
      .wdata ({fetch_pc, imem_data_i}),
      .rdata (head),
      .count (count)
   );

   assign instr_valid_o = (count != '0);
   assign instr_pc_o    = head[ENT_W-1:INSTR_W];
   assign instr_o       = head[INSTR_W-1:0];

endmodule
